// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing generator: the
// per-axis phase enum, timing constant sets for common modes, the
// counter-to-phase decode and the colour-bar palette.
package video_timing_pkg;

    // Position of a counter within one line (h) or one frame (v).
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } phase_t;

    // Full timing description of a video mode.
    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t TIMING_640X480_60 = '{
        h_active: 640,  h_fp: 16,  h_sync: 96, h_bp: 48,
        v_active: 480,  v_fp: 10,  v_sync: 2,  v_bp: 33
    };

    localparam timing_t TIMING_1280X720_60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
    };

    // Regions run ACTIVE, FP, SYNC, BP; anything past SYNC is back porch.
    function automatic phase_t phase_decode(
        input int unsigned cnt,
        input int unsigned len_active,
        input int unsigned len_fp,
        input int unsigned len_sync
    );
        if (cnt < len_active)
            return ACTIVE;
        else if (cnt < len_active + len_fp)
            return FP;
        else if (cnt < len_active + len_fp + len_sync)
            return SYNC;
        else
            return BP;
    endfunction

    // Eight vertical bars, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;  // white
            3'd1:    return 24'hFFFF00;  // yellow
            3'd2:    return 24'h00FFFF;  // cyan
            3'd3:    return 24'h00FF00;  // green
            3'd4:    return 24'hFF00FF;  // magenta
            3'd5:    return 24'hFF0000;  // red
            3'd6:    return 24'h0000FF;  // blue
            default: return 24'h000000;  // black
        endcase
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One timing axis: a wrapping counter over ACTIVE+FP+SYNC+BP positions
// with a registered phase state kept in lock-step with the count. The
// look-ahead (phase_next) lets the top predict the following cycle.
module vtg_axis_counter
    import video_timing_pkg::*;
#(
    parameter int A_LEN    = 640,
    parameter int FP_LEN   = 16,
    parameter int SYNC_LEN = 96,
    parameter int BP_LEN   = 48,
    parameter int W        = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output phase_t       phase,
    output phase_t       phase_next,
    output logic         wrap
);

    localparam int           TOTAL = A_LEN + FP_LEN + SYNC_LEN + BP_LEN;
    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;
    phase_t       phase_reg;

    // Next count and next phase; the phase always matches the count it will sit on.
    always_comb begin
        cnt_next = cnt_reg;
        wrap     = 1'b0;
        if (en) begin
            if (cnt_reg == LAST) begin
                cnt_next = '0;
                wrap     = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
        phase_next = phase_decode(32'(cnt_next), A_LEN, FP_LEN, SYNC_LEN);
    end

    // Counter and phase state registers; reset returns to position 0 (ACTIVE).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            phase_reg <= ACTIVE;
        end else begin
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
        end
    end

    assign cnt   = cnt_reg;
    assign phase = phase_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: h/v counters running from the pixel clock while
// the PLL is locked, registered sync/de/position outputs one clock behind
// the counters, and a one-clock-early pixel_req for fetch latency.
// Optional colour-bar output rgb is built when VIDEO_TIMING_GEN_PATTERN_EN
// is defined.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pll_lock,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        pixel_req
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    ,
    output logic [23:0] rgb
`endif
);

    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    phase_t      h_phase, h_phase_next;
    phase_t      v_phase, v_phase_next;
    logic        h_wrap;
    logic        v_wrap_unused;

    logic        hsync_reg, vsync_reg, de_reg, frame_start_reg, pixel_req_reg;
    logic [11:0] x_reg;
    logic [10:0] y_reg;

    vtg_axis_counter #(
        .A_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .W(12)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .en         (pll_lock),
        .cnt        (h_cnt),
        .phase      (h_phase),
        .phase_next (h_phase_next),
        .wrap       (h_wrap)
    );

    // The vertical axis steps once per completed line.
    vtg_axis_counter #(
        .A_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .W(11)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .cnt        (v_cnt),
        .phase      (v_phase),
        .phase_next (v_phase_next),
        .wrap       (v_wrap_unused)
    );

    logic de_now, de_ahead;
    assign de_now   = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign de_ahead = (h_phase_next == ACTIVE) && (v_phase_next == ACTIVE);

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    // Bar index = number of bar boundaries already passed on this line.
    logic [6:0] past_edge;
    logic [2:0] bar_idx;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
            assign past_edge[gi-1] = (32'(h_cnt) >= 32'(gi * BAR_W));
        end
    endgenerate
    assign bar_idx = 3'($countones(past_edge));

    logic [23:0] rgb_reg;
`endif

    // Output registers describe the counter state of the previous clock.
    always_ff @(posedge clk) begin
        if (reset || !pll_lock) begin
            hsync_reg       <= ~SYNC_ON;
            vsync_reg       <= ~SYNC_ON;
            de_reg          <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
            pixel_req_reg   <= 1'b0;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
            rgb_reg         <= '0;
`endif
        end else begin
            hsync_reg       <= (h_phase == SYNC) ? SYNC_ON : ~SYNC_ON;
            vsync_reg       <= (v_phase == SYNC) ? SYNC_ON : ~SYNC_ON;
            de_reg          <= de_now;
            x_reg           <= de_now ? h_cnt : 12'd0;
            y_reg           <= de_now ? v_cnt : 11'd0;
            frame_start_reg <= (h_cnt == 12'd0) && (v_cnt == 11'd0);
            pixel_req_reg   <= de_ahead;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
            rgb_reg         <= de_now ? bar_colour(bar_idx) : 24'd0;
`endif
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign frame_start = frame_start_reg;
    assign pixel_req   = pixel_req_reg;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    assign rgb         = rgb_reg;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced mode (31 x 21 clocks) so
// whole frames fit in a short run. A behavioural model pushes the expected
// outputs of every clock into a scoreboard queue; a monitor pops and
// compares them. Scenario tasks add interval and boundary checks.
module tb_video_timing_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int VA = 12, VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pll_lock = 1'b0;
    logic        hsync, vsync, de, frame_start, pixel_req;
    logic [11:0] x;
    logic [10:0] y;
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    logic [23:0] rgb;
`endif

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .pixel_req   (pixel_req)
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        ,
        .rgb         (rgb)
`endif
    );

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [11:0] x;
        logic [10:0] y;
        logic        fs;
        logic        pr;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   mh = 0;
    int   mv = 0;

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Drive one clock of stimulus; the model predicts what the DUT shows after this edge.
    task automatic step(input logic r, input logic l);
        exp_t e;
        int nh, nv;
        reset    = r;
        pll_lock = l;
        e        = '0;
        e.hsync  = 1'b1;
        e.vsync  = 1'b1;
        if (r) begin
            mh = 0;
            mv = 0;
        end else if (l) begin
            e.de    = (mh < HA) && (mv < VA);
            e.hsync = !((mh >= HA + HF) && (mh < HA + HF + HS));
            e.vsync = !((mv >= VA + VF) && (mv < VA + VF + VS));
            e.x     = e.de ? 12'(mh) : 12'd0;
            e.y     = e.de ? 11'(mv) : 11'd0;
            e.fs    = (mh == 0) && (mv == 0);
            e.rgb   = e.de ? bar_rgb(mh / (HA / 8)) : 24'd0;
            nh      = (mh == HT - 1) ? 0 : mh + 1;
            nv      = (mh == HT - 1) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;
            e.pr    = (nh < HA) && (nv < VA);
            mh      = nh;
            mv      = nv;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every clock's outputs against the queued prediction.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({hsync, vsync, de, x, y, frame_start, pixel_req} !==
                {e.hsync, e.vsync, e.de, e.x, e.y, e.fs, e.pr}) begin
                bad++;
                $display("FAIL outputs t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b pr=%b want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b pr=%b",
                         $time, hsync, vsync, de, x, y, frame_start, pixel_req,
                         e.hsync, e.vsync, e.de, e.x, e.y, e.fs, e.pr);
            end
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
            total++;
            if (rgb !== e.rgb) begin
                bad++;
                $display("FAIL rgb t=%0t got %h want %h", $time, rgb, e.rgb);
            end
`endif
        end
    end

    task automatic test_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        total++;
        if ({de, x, y, frame_start, pixel_req, hsync, vsync} !== {1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got de=%b x=%0d y=%0d fs=%b pr=%b hs=%b vs=%b want 0 0 0 0 0 1 1",
                     de, x, y, frame_start, pixel_req, hsync, vsync);
        end
        $display("test_reset: reset held 3 clocks");
    endtask

    task automatic test_frames();
        int   last_fs = -1, run = 0, de_frame = 0, de_rise = -1, hs_fall = 0, vs_fall = 0;
        logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1, p_pr = 1'b0;
        for (int c = 0; c < 2 * FRAME + 2; c++) begin
            step(1'b0, 1'b1);
            if (c > 0) begin
                total++;
                if (p_pr !== de) begin
                    bad++;
                    $display("FAIL pixel_req_lookahead c=%0d prev pixel_req=%b de=%b", c, p_pr, de);
                end
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    total++;
                    if (c - last_fs !== FRAME) begin
                        bad++;
                        $display("FAIL frame_period got %0d want %0d", c - last_fs, FRAME);
                    end
                    total++;
                    if (de_frame !== HA * VA) begin
                        bad++;
                        $display("FAIL de_per_frame got %0d want %0d", de_frame, HA * VA);
                    end
                end
                $display("test_frames: frame_start at cycle %0d", c);
                last_fs  = c;
                de_frame = 0;
            end
            if (de === 1'b1) de_frame++;
            if (de === 1'b1 && p_de !== 1'b1) begin
                de_rise = c;
                run     = 0;
            end
            if (de === 1'b1) run++;
            if (de !== 1'b1 && p_de === 1'b1) begin
                total++;
                if (run !== HA) begin
                    bad++;
                    $display("FAIL de_run got %0d want %0d", run, HA);
                end
            end
            if (hsync === 1'b0 && p_hs === 1'b1) begin
                hs_fall = c;
                if (de_rise >= 0) begin
                    total++;
                    if (c - de_rise !== HA + HF) begin
                        bad++;
                        $display("FAIL hsync_offset got %0d want %0d", c - de_rise, HA + HF);
                    end
                    de_rise = -1;
                end
            end
            if (hsync === 1'b1 && p_hs === 1'b0) begin
                total++;
                if (c - hs_fall !== HS) begin
                    bad++;
                    $display("FAIL hsync_width got %0d want %0d", c - hs_fall, HS);
                end
            end
            if (vsync === 1'b0 && p_vs === 1'b1) begin
                vs_fall = c;
                total++;
                if (c - last_fs !== (VA + VF) * HT) begin
                    bad++;
                    $display("FAIL vsync_start got %0d want %0d", c - last_fs, (VA + VF) * HT);
                end
            end
            if (vsync === 1'b1 && p_vs === 1'b0) begin
                total++;
                if (c - vs_fall !== VS * HT) begin
                    bad++;
                    $display("FAIL vsync_width got %0d want %0d", c - vs_fall, VS * HT);
                end
            end
            p_de = de;
            p_hs = hsync;
            p_vs = vsync;
            p_pr = pixel_req;
        end
    endtask

    task automatic test_pll_lock();
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (mh == 7 && mv == 5) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b1);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL lock_position got h=%0d v=%0d want h=7 v=5", mh, mv);
        end
        for (int i = 0; i < 37; i++) step(1'b0, 1'b0);
        total++;
        if ({de, pixel_req, frame_start, hsync, vsync} !== 5'b00011) begin
            bad++;
            $display("FAIL lock_idle got de=%b pr=%b fs=%b hs=%b vs=%b want 0 0 0 1 1",
                     de, pixel_req, frame_start, hsync, vsync);
        end
        step(1'b0, 1'b1);
        total++;
        if ({de, x, y} !== {1'b1, 12'd7, 11'd5}) begin
            bad++;
            $display("FAIL lock_resume got de=%b x=%0d y=%0d want 1 7 5", de, x, y);
        end
        step(1'b0, 1'b1);
        total++;
        if (x !== 12'd8) begin
            bad++;
            $display("FAIL lock_advance got x=%0d want 8", x);
        end
        $display("test_pll_lock: resumed at x=7 y=5");
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (mh == 3 && mv == 10) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b1);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reset_mid_position got h=%0d v=%0d want h=3 v=10", mh, mv);
        end
        step(1'b1, 1'b1);
        total++;
        if ({de, x, y, frame_start, pixel_req, hsync, vsync} !== {1'b0, 12'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_state got de=%b x=%0d y=%0d fs=%b pr=%b hs=%b vs=%b want 0 0 0 0 0 1 1",
                     de, x, y, frame_start, pixel_req, hsync, vsync);
        end
        step(1'b0, 1'b1);
        total++;
        if ({frame_start, de, x, y} !== {1'b1, 1'b1, 12'd0, 11'd0}) begin
            bad++;
            $display("FAIL reset_release got fs=%b de=%b x=%0d y=%0d want 1 1 0 0", frame_start, de, x, y);
        end
        step(1'b0, 1'b1);
        total++;
        if ({frame_start, x} !== {1'b0, 12'd1}) begin
            bad++;
            $display("FAIL reset_release_next got fs=%b x=%0d want 0 1", frame_start, x);
        end
        $display("test_reset_mid: restart after reset at v=10");
    endtask

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    task automatic test_pattern();
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 1'b1);
            if (de === 1'b1 && y === 11'd3) begin
                if (x === 12'd0) begin
                    total++;
                    if (rgb !== 24'hFFFFFF) begin
                        bad++;
                        $display("FAIL rgb_white got %h want FFFFFF", rgb);
                    end
                end
                if (x === 12'd12) begin
                    total++;
                    if (rgb !== 24'h0000FF) begin
                        bad++;
                        $display("FAIL rgb_blue got %h want 0000FF", rgb);
                    end
                end
                if (x === 12'd15) begin
                    total++;
                    if (rgb !== 24'h000000) begin
                        bad++;
                        $display("FAIL rgb_black got %h want 000000", rgb);
                    end
                end
            end
        end
        $display("test_pattern: one frame of colour bars");
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_pll_lock();
        test_reset_mid();
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        test_pattern();
`endif
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drained got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
